// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } seq_state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: compares the last PAT_W sampled bits of X against a
// programmable pattern, with overlapping or non-overlapping detection and a match count.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             X,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  generate
    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
    end
  endgenerate

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  seq_state_t        state_q;

  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], X};
    fill_n = fill;
    match  = 1'b0;
    if (fill != FILL_FULL) begin
      fill_n = fill + 1'b1;
    end
    if (en && !clear && (fill_n == FILL_FULL) && (hist_n == pattern)) begin
      match = 1'b1;
    end
  end

  // A non-overlap match restarts the fill so matched bits cannot be reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      state_q <= IDLE;
      Y       <= 1'b0;
    end else if (clear) begin
      hist    <= '0;
      fill    <= '0;
      state_q <= IDLE;
      Y       <= 1'b0;
    end else if (en) begin
      hist <= hist_n;
      Y    <= match;
      if (match && !overlap) begin
        fill    <= '0;
        state_q <= IDLE;
      end else begin
        fill <= fill_n;
        unique case (state_q)
          IDLE:    state_q <= (fill_n == FILL_FULL) ? ARMED : FILL;
          FILL:    state_q <= (fill_n == FILL_FULL) ? ARMED : FILL;
          ARMED:   state_q <= ARMED;
          default: state_q <= IDLE;
        endcase
      end
    end else begin
      Y <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .inc  (match),
    .count(match_cnt)
  );

  assign state = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares after each edge.
module tb_seq_detect_param;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             x;
  logic [PAT_W-1:0] pat;
  logic             ovl;
  logic             clr;

  logic             y8, y2;
  logic [7:0]       cnt8;
  logic [1:0]       cnt2;
  logic [1:0]       st8, st2;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .X(x), .pattern(pat), .overlap(ovl),
    .clear(clr), .Y(y8), .match_cnt(cnt8), .state(st8)
  );

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .X(x), .pattern(pat), .overlap(ovl),
    .clear(clr), .Y(y2), .match_cnt(cnt2), .state(st2)
  );

  typedef struct {
    logic       y;
    int         cnt;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  bit   bits_q[$];
  int   model_cnt;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] model_state();
    if (bits_q.size() == 0) return 2'd0;
    if (bits_q.size() < PAT_W) return 2'd1;
    return 2'd2;
  endfunction

  // Oldest retained bit is the pattern MSB.
  function automatic logic [PAT_W-1:0] model_window();
    logic [PAT_W-1:0] v = '0;
    for (int i = 0; i < bits_q.size(); i++) v[PAT_W-1-i] = bits_q[i];
    return v;
  endfunction

  function automatic exp_t model_step(input bit e, input bit b, input bit c);
    exp_t r;
    r.y = 1'b0;
    if (c) begin
      bits_q.delete();
      model_cnt = 0;
    end else if (e) begin
      bits_q.push_back(b);
      if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
      if (bits_q.size() == PAT_W && model_window() == pat) begin
        r.y = 1'b1;
        model_cnt++;
        if (!ovl) bits_q.delete();
      end
    end
    r.cnt = model_cnt;
    r.st  = model_state();
    return r;
  endfunction

  task automatic drive(input bit e, input bit b, input bit c);
    en  = e;
    x   = b;
    clr = c;
    sb.push_back(model_step(e, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    logic [15:0] v = bits;
    for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i], 1'b0);
  endtask

  task automatic hold_reset(input int cycles);
    exp_t z;
    bits_q.delete();
    model_cnt = 0;
    z.y = 1'b0; z.cnt = 0; z.st = 2'd0;
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      en = 1'($urandom_range(0, 1));
      x  = 1'($urandom_range(0, 1));
      sb.push_back(z);
      @(posedge clk);
      #1;
    end
    en    = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("y",    32'(y8),   32'(e.y));
        check("cnt8", 32'(cnt8), (e.cnt > 255) ? 32'd255 : 32'(e.cnt));
        check("st",   32'(st8),  32'(e.st));
        check("y_sat",   32'(y2),   32'(e.y));
        check("cnt_sat", 32'(cnt2), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
        check("st_sat",  32'(st2),  32'(e.st));
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; en = 1'b0; x = 1'b0; clr = 1'b0;
    pat = 4'b1011; ovl = 1'b1;
    bits_q.delete();
    model_cnt = 0;

    hold_reset(5);

    // Overlap: matches after samples 4 and 7.
    drive(1'b0, 1'b0, 1'b1);
    stream(16'b1011011, 7);
    check("ovl_cnt", 32'(cnt8), 32'd2);

    // Non-overlap: single match, refilling afterwards.
    ovl = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    stream(16'b1011011, 7);
    check("novl_cnt", 32'(cnt8), 32'd1);
    check("novl_st",  32'(st8),  32'd1);

    // Enable gating with idle gaps between bits.
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] s = 4'b1011;
      drive(1'b1, s[i], 1'b0);
      if (i == 0) check("gate_y", 32'(y8), 32'd1);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("gate_cnt", 32'(cnt8), 32'd1);

    // Saturation with back-to-back overlap matches.
    pat = 4'b1111; ovl = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    stream(16'hFF, 8);
    check("sat_cnt2", 32'(cnt2), 32'd3);
    check("sat_cnt8", 32'(cnt8), 32'd5);

    // Clear mid-pattern discards its bit, then a fresh match.
    pat = 4'b1011;
    drive(1'b0, 1'b0, 1'b1);
    stream(16'b101, 3);
    drive(1'b1, 1'b1, 1'b1);
    check("clr_st",  32'(st8),  32'd0);
    check("clr_cnt", 32'(cnt8), 32'd0);
    stream(16'b1011, 4);
    check("post_clr_y", 32'(y8), 32'd1);

    // Asynchronous reset lands between edges while Y and the count are set.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y",   32'(y8),   32'd0);
    check("arst_cnt", 32'(cnt8), 32'd0);
    check("arst_st",  32'(st8),  32'd0);
    hold_reset(2);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) pat = 4'($urandom);
      if ($urandom_range(0, 99) < 3) ovl = 1'($urandom);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 99) < 2));
    end
    en = 1'b0; clr = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
